spi_master_sched: RTL and testbench

- Round-robin scheduler that shares one byte-level SPI master (spi_module_trial) between NUM_REQ requesters.
- Frames multi-byte transactions with a per-requester active-low chip select, including setup, hold and inter-transaction gap timing.
- Streams TX bytes from the granted requester into the master and routes RX bytes back to that requester.
- Sits between the SPI master's i_TX_Byte/i_TX_DV/o_TX_Ready/o_RX_DV/o_RX_Byte interface and the requester clients.

---
 rtl/spi_master_sched.sv | 185 ++++++++++++++++++
 tb/tb_spi_master_sched.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_sched.sv
// Round-robin scheduler sharing one byte-level SPI master between NUM_REQ clients.
// Frames each multi-byte transaction with its own chip select plus setup/hold/gap timing.
module spi_master_sched #(
  parameter int NUM_REQ       = 2,
  parameter int LEN_W         = 4,
  parameter int CS_SETUP_CLKS = 2,
  parameter int CS_HOLD_CLKS  = 2,
  parameter int CS_GAP_CLKS   = 4
) (
  input  logic                       i_Clk,
  input  logic                       i_Rst_L,
  input  logic [NUM_REQ-1:0]         i_Req,
  input  logic [NUM_REQ*LEN_W-1:0]   i_Len,
  input  logic [NUM_REQ*8-1:0]       i_TX_Byte,
  input  logic [NUM_REQ-1:0]         i_TX_Valid,
  output logic [NUM_REQ-1:0]         o_TX_Ack,
  output logic [NUM_REQ-1:0]         o_Grant,
  output logic [7:0]                 o_RX_Byte,
  output logic [NUM_REQ-1:0]         o_RX_DV,
  output logic [NUM_REQ-1:0]         o_Done,
  output logic [NUM_REQ-1:0]         o_CS_n,
  output logic                       o_Busy,
  output logic [7:0]                 o_M_TX_Byte,
  output logic                       o_M_TX_DV,
  input  logic                       i_M_TX_Ready,
  input  logic                       i_M_RX_DV,
  input  logic [7:0]                 i_M_RX_Byte
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TMR_W = 16;

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_LOAD, S_WAIT_RX, S_HOLD, S_DONE, S_GAP
  } state_t;

  state_t               state_q;
  logic [IDX_W-1:0]     ptr_q, own_q;
  logic [LEN_W-1:0]     cnt_q;
  logic [TMR_W-1:0]     tmr_q;
  logic [NUM_REQ-1:0]   grant_q, cs_n_q, ack_q, rx_dv_q, done_q;
  logic [7:0]           rx_byte_q, m_byte_q;
  logic                 m_dv_q, busy_q;

  logic                 win_vld_d;
  logic [IDX_W-1:0]     win_d;
  logic [NUM_REQ-1:0]   win_oh_d;
  logic [LEN_W-1:0]     win_len_d;
  logic [7:0]           own_byte_d;
  logic                 own_vld_d;

  function automatic logic [IDX_W-1:0] rr_idx(input logic [IDX_W-1:0] base, input int k);
    return IDX_W'((int'(base) + k) % NUM_REQ);
  endfunction

  // Scan from farthest to nearest so the last hit is the first requester after the pointer.
  always_comb begin
    win_vld_d = 1'b0;
    win_d     = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (i_Req[rr_idx(ptr_q, k)]) begin
        win_vld_d = 1'b1;
        win_d     = rr_idx(ptr_q, k);
      end
    end
  end

  assign win_oh_d = NUM_REQ'(1) << win_d;

  always_comb begin
    win_len_d  = '0;
    own_byte_d = '0;
    own_vld_d  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (IDX_W'(i) == win_d) win_len_d = i_Len[i*LEN_W +: LEN_W];
      if (IDX_W'(i) == own_q) begin
        own_byte_d = i_TX_Byte[i*8 +: 8];
        own_vld_d  = i_TX_Valid[i];
      end
    end
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      state_q   <= S_IDLE;
      ptr_q     <= IDX_W'(NUM_REQ - 1);
      own_q     <= '0;
      cnt_q     <= '0;
      tmr_q     <= '0;
      grant_q   <= '0;
      cs_n_q    <= '1;
      ack_q     <= '0;
      rx_dv_q   <= '0;
      done_q    <= '0;
      rx_byte_q <= '0;
      m_byte_q  <= '0;
      m_dv_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      ack_q   <= '0;
      rx_dv_q <= '0;
      done_q  <= '0;
      m_dv_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (win_vld_d) begin
            grant_q <= win_oh_d;
            own_q   <= win_d;
            ptr_q   <= win_d;
            cnt_q   <= win_len_d;
            tmr_q   <= '0;
            busy_q  <= 1'b1;
            // Zero-length requests complete without touching chip select.
            if (win_len_d == '0) begin
              state_q <= S_DONE;
            end else begin
              cs_n_q  <= ~win_oh_d;
              state_q <= S_SETUP;
            end
          end
        end
        S_SETUP: begin
          if (tmr_q == TMR_W'(CS_SETUP_CLKS - 1)) begin
            tmr_q   <= '0;
            state_q <= S_LOAD;
          end else begin
            tmr_q <= tmr_q + 1'b1;
          end
        end
        S_LOAD: begin
          if (own_vld_d && i_M_TX_Ready) begin
            m_byte_q <= own_byte_d;
            m_dv_q   <= 1'b1;
            ack_q    <= grant_q;
            cnt_q    <= cnt_q - 1'b1;
            state_q  <= S_WAIT_RX;
          end
        end
        S_WAIT_RX: begin
          if (i_M_RX_DV) begin
            rx_byte_q <= i_M_RX_Byte;
            rx_dv_q   <= grant_q;
            state_q   <= (cnt_q == '0) ? S_HOLD : S_LOAD;
          end
        end
        S_HOLD: begin
          if (tmr_q == TMR_W'(CS_HOLD_CLKS - 1)) begin
            tmr_q   <= '0;
            cs_n_q  <= '1;
            state_q <= S_DONE;
          end else begin
            tmr_q <= tmr_q + 1'b1;
          end
        end
        S_DONE: begin
          done_q  <= grant_q;
          grant_q <= '0;
          tmr_q   <= '0;
          state_q <= S_GAP;
        end
        S_GAP: begin
          if (tmr_q == TMR_W'(CS_GAP_CLKS - 1)) begin
            tmr_q   <= '0;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            tmr_q <= tmr_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_TX_Ack    = ack_q;
  assign o_Grant     = grant_q;
  assign o_RX_Byte   = rx_byte_q;
  assign o_RX_DV     = rx_dv_q;
  assign o_Done      = done_q;
  assign o_CS_n      = cs_n_q;
  assign o_Busy      = busy_q;
  assign o_M_TX_Byte = m_byte_q;
  assign o_M_TX_DV   = m_dv_q;

endmodule

// File: tb/tb_spi_master_sched.sv
// Scoreboard bench for spi_master_sched: behavioural requesters and SPI master,
// round-robin reference model feeding expectation queues, independent monitor.
module tb_spi_master_sched;
  localparam int NR = 2;
  localparam int LW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NR-1:0]    req = '0, valid = '0;
  logic [NR*LW-1:0] len_v = '0;
  logic [NR*8-1:0]  txb_v = '0;
  logic             m_ready = 1'b1, m_rx_dv = 1'b0;
  logic [7:0]       m_rx_byte = '0;
  logic [NR-1:0]    tx_ack, grant, rx_dv, done, cs_n;
  logic [7:0]       rx_byte, m_tx_byte;
  logic             m_tx_dv, busy;

  always #5 clk = ~clk;

  spi_master_sched #(.NUM_REQ(NR), .LEN_W(LW), .CS_SETUP_CLKS(2), .CS_HOLD_CLKS(2),
                     .CS_GAP_CLKS(4)) dut (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_Req(req), .i_Len(len_v), .i_TX_Byte(txb_v),
    .i_TX_Valid(valid), .o_TX_Ack(tx_ack), .o_Grant(grant), .o_RX_Byte(rx_byte),
    .o_RX_DV(rx_dv), .o_Done(done), .o_CS_n(cs_n), .o_Busy(busy),
    .o_M_TX_Byte(m_tx_byte), .o_M_TX_DV(m_tx_dv), .i_M_TX_Ready(m_ready),
    .i_M_RX_DV(m_rx_dv), .i_M_RX_Byte(m_rx_byte)
  );

  int checks = 0, errors = 0;

  task automatic chk(input bit ok, input string name, input int act, input int exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [NR-1:0] oh(input int r);
    return NR'(1) << r;
  endfunction

  // Per-requester transaction rings shared by stimulus, driver and model.
  logic [7:0] txb[NR][8][16];
  int txl[NR][8];
  int hd[NR], tl[NR], pred_hd[NR];
  int model_ptr = NR - 1;
  logic [7:0] rx_xor = 8'h00;
  bit force_nready = 1'b0, noise_en = 1'b0;
  bit stall_first[NR];

  logic [15:0] exp_grant[$], exp_mtx[$], exp_ack[$], exp_rx[$], exp_done[$];

  task automatic issue(input int r, input int len, input logic [127:0] b);
    int s;
    s = tl[r] % 8;
    txl[r][s] = len;
    for (int i = 0; i < 16; i++) txb[r][s][i] = b[i*8 +: 8];
    tl[r]++;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Reference model: serve pending transactions in round-robin order after the last winner.
  task automatic predict();
    int cnt[NR];
    int r, s, k;
    bit found;
    for (int i = 0; i < NR; i++) cnt[i] = tl[i] - pred_hd[i];
    forever begin
      found = 1'b0;
      k = 1;
      while (!found && k <= NR) begin
        r = (model_ptr + k) % NR;
        if (cnt[r] > 0) found = 1'b1;
        k++;
      end
      if (!found) break;
      s = pred_hd[r] % 8;
      exp_grant.push_back(16'(r));
      for (int i = 0; i < txl[r][s]; i++) begin
        exp_mtx.push_back({8'(r), txb[r][s][i]});
        exp_ack.push_back(16'(r));
        exp_rx.push_back({8'(r), txb[r][s][i] ^ rx_xor});
      end
      exp_done.push_back({8'(txl[r][s]), 8'(r)});
      pred_hd[r]++;
      cnt[r]--;
      model_ptr = r;
    end
  endtask

  // Requester clients and SPI master model.
  int bidx[NR], stall[NR];
  bit active[NR];
  bit m_busy = 1'b0;
  int m_lat = 0;
  logic [7:0] m_hold = '0;

  always @(posedge clk) begin : drv
    int s;
    #2;
    if (!rst_n) begin
      req = '0; valid = '0; m_rx_dv = 1'b0; m_busy = 1'b0; m_ready = 1'b1;
      for (int r = 0; r < NR; r++) begin
        active[r] = 1'b0; hd[r] = tl[r]; stall[r] = 0; bidx[r] = 0;
      end
    end else begin
      m_rx_dv   = 1'b0;
      m_rx_byte = 8'($urandom);
      if (m_tx_dv) begin
        m_busy = 1'b1; m_hold = m_tx_byte; m_lat = $urandom_range(4, 20);
      end else if (m_busy) begin
        if (m_lat == 0) begin
          m_rx_dv = 1'b1; m_rx_byte = m_hold ^ rx_xor; m_busy = 1'b0;
        end else m_lat--;
      end else if (noise_en && $urandom_range(0, 7) == 0) begin
        m_rx_dv = 1'b1;
      end
      m_ready = !m_busy && !force_nready;
      for (int r = 0; r < NR; r++) begin
        if (stall[r] > 0) stall[r]--;
        if (active[r]) begin
          if (tx_ack[r]) begin
            bidx[r]++;
            if (stall_first[r] && bidx[r] == 1) stall[r] = 20;
          end
          if (done[r]) begin active[r] = 1'b0; hd[r]++; end
        end else if (hd[r] != tl[r]) begin
          active[r] = 1'b1; bidx[r] = 0;
        end
        s = hd[r] % 8;
        req[r] = active[r];
        len_v[r*LW +: LW] = active[r] ? LW'(txl[r][s]) : LW'($urandom);
        valid[r] = active[r] ? (bidx[r] < txl[r][s] && stall[r] == 0) : 1'($urandom);
        txb_v[r*8 +: 8] = (active[r] && bidx[r] < 16) ? txb[r][s][bidx[r]] : 8'($urandom);
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents an event; checks CS framing.
  int mtx_count = 0, ack_count = 0, rx_count = 0;
  logic [NR-1:0] prev_grant = '0, prev_cs = '1;
  int since_cs_fall = 0, since_rx = 1000, gap_run = 1000;
  bit cs_seen_low = 1'b0, first_dv = 1'b0;

  always @(posedge clk) begin : mon
    logic [15:0] e;
    #1;
    if (!rst_n) begin
      prev_grant = '0; prev_cs = '1; gap_run = 1000; since_rx = 1000;
      since_cs_fall = 0; cs_seen_low = 1'b0; first_dv = 1'b0;
    end else begin
      chk($countones(~cs_n) <= 1 && ((~cs_n) & ~grant) == '0 && !(m_tx_dv && rx_dv != '0)
          && !(m_tx_dv && cs_n == '1), "invariant", {cs_n, grant, rx_dv}, 0);
      since_rx++;
      if (rx_dv != '0) since_rx = 0;
      if (prev_cs == '1 && cs_n != '1) begin
        chk(gap_run >= 4, "cs_gap", gap_run, 4);
        since_cs_fall = 0; first_dv = 1'b1;
      end else since_cs_fall++;
      if (prev_cs != '1 && cs_n == '1) begin
        chk(since_rx >= 2, "cs_hold", since_rx, 2);
        gap_run = 0;
      end
      if (cs_n == '1) gap_run++;
      if (prev_grant == '0 && grant != '0) begin
        cs_seen_low = 1'b0;
        if (exp_grant.size() == 0) chk(1'b0, "unexpected_grant", grant, 0);
        else begin e = exp_grant.pop_front(); chk(grant == oh(e), "grant_order", grant, oh(e)); end
      end
      if (cs_n != '1) cs_seen_low = 1'b1;
      if (m_tx_dv) begin
        mtx_count++;
        if (first_dv) begin chk(since_cs_fall >= 2, "cs_setup", since_cs_fall, 2); first_dv = 1'b0; end
        if (exp_mtx.size() == 0) chk(1'b0, "unexpected_m_tx_dv", m_tx_byte, 0);
        else begin
          e = exp_mtx.pop_front();
          chk(m_tx_byte == e[7:0], "m_tx_byte", m_tx_byte, e[7:0]);
          chk(grant == oh(e[15:8]), "grant_at_tx", grant, oh(e[15:8]));
        end
      end
      if (tx_ack != '0) begin
        ack_count++;
        if (exp_ack.size() == 0) chk(1'b0, "unexpected_ack", tx_ack, 0);
        else begin e = exp_ack.pop_front(); chk(tx_ack == oh(e), "tx_ack", tx_ack, oh(e)); end
      end
      if (rx_dv != '0) begin
        rx_count++;
        if (exp_rx.size() == 0) chk(1'b0, "unexpected_rx_dv", rx_dv, 0);
        else begin
          e = exp_rx.pop_front();
          chk(rx_dv == oh(e[15:8]) && rx_byte == e[7:0], "rx",
              {rx_dv, rx_byte}, {oh(e[15:8]), e[7:0]});
        end
      end
      if (done != '0) begin
        if (exp_done.size() == 0) chk(1'b0, "unexpected_done", done, 0);
        else begin
          e = exp_done.pop_front();
          chk(done == oh(e[7:0]), "done", done, oh(e[7:0]));
          chk(cs_seen_low == (e[15:8] != 0), "cs_activity", cs_seen_low, (e[15:8] != 0));
        end
      end
      prev_grant = grant;
      prev_cs    = cs_n;
    end
  end

  task automatic tick();
    @(posedge clk); #3;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((exp_grant.size() + exp_mtx.size() + exp_ack.size() + exp_rx.size()
            + exp_done.size()) != 0 || busy) begin
      tick(); n++;
      if (n > 5000) break;
    end
    chk(n <= 5000, name, n, 5000);
  endtask

  initial begin : watchdog
    #800000;
    $display("FAIL watchdog: simulation time limit reached, got %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n, a0, base, rxb;
    bit bad;
    repeat (3) tick();
    chk(cs_n == '1, "rst_cs_n", cs_n, 3);
    chk(grant == '0, "rst_grant", grant, 0);
    chk(busy == 1'b0, "rst_busy", busy, 0);
    chk(m_tx_dv == 1'b0 && m_tx_byte == 8'h00, "rst_m_tx", {m_tx_dv, m_tx_byte}, 0);
    chk(rx_byte == 8'h00, "rst_rx_byte", rx_byte, 0);
    chk((tx_ack | rx_dv | done) == '0, "rst_pulses", {tx_ack, rx_dv, done}, 0);
    rst_n = 1'b1;
    tick();

    // Both requesters held, one byte each, twice: alternating grants.
    for (int i = 0; i < 2; i++) begin
      issue(0, 1, rnd128()); issue(1, 1, rnd128());
    end
    predict();
    wait_drain("drain_rr");

    // Loopback-style transfer of C1/BE/EF from requester 0.
    rx_xor = 8'h00;
    issue(0, 3, 128'h0000000000000000_0000000000EFBEC1);
    predict();
    wait_drain("drain_loopback");

    // Zero-length request: done two cycles after the request, no CS activity.
    issue(1, 0, rnd128());
    predict();
    n = 0;
    while (!req[1] && n < 10) begin tick(); n++; end
    n = 0; bad = 1'b0;
    while (n < 10) begin
      tick(); n++;
      if (cs_n[1] == 1'b0 || m_tx_dv) bad = 1'b1;
      if (done[1]) break;
    end
    chk(n == 2, "len0_latency", n, 2);
    chk(!bad, "len0_quiet", bad, 0);
    wait_drain("drain_len0");

    // TX valid withheld after the first byte: CS stays low, no master strobe.
    rx_xor = 8'h3C;
    stall_first[0] = 1'b1;
    issue(0, 2, rnd128());
    predict();
    a0 = ack_count; n = 0;
    while (ack_count == a0 && n < 200) begin tick(); n++; end
    chk(n < 200, "stall_first_ack", n, 200);
    rxb = rx_count; base = mtx_count; bad = 1'b0;
    repeat (18) begin
      tick();
      if (cs_n[0] != 1'b0 || mtx_count != base) bad = 1'b1;
    end
    chk(!bad, "stall_hold", bad, 0);
    stall_first[0] = 1'b0;
    wait_drain("drain_stall");
    chk(rx_count - rxb == 2, "stall_rx_pulses", rx_count - rxb, 2);

    // Master not ready on LOAD entry: strobe follows the cycle after Ready rises.
    force_nready = 1'b1;
    issue(0, 1, rnd128());
    predict();
    base = mtx_count;
    repeat (12) tick();
    chk(mtx_count == base && cs_n[0] == 1'b0, "ready_withheld", mtx_count - base, 0);
    force_nready = 1'b0;
    tick();
    chk(m_tx_dv == 1'b0, "dv_before_ready_seen", m_tx_dv, 0);
    tick();
    chk(m_tx_dv == 1'b1, "dv_after_ready", m_tx_dv, 1);
    wait_drain("drain_ready");

    // Randomised rounds with stray master RX strobes outside WAIT_RX.
    noise_en = 1'b1;
    for (int rnd = 0; rnd < 8; rnd++) begin
      rx_xor = 8'($urandom);
      for (int r = 0; r < NR; r++) begin
        if ($urandom_range(0, 3) != 0) begin
          n = $urandom_range(1, 2);
          for (int t = 0; t < n; t++) issue(r, $urandom_range(0, 5), rnd128());
        end
      end
      predict();
      wait_drain("drain_random");
    end
    noise_en = 1'b0;

    // Reset in the middle of a four-byte transfer.
    issue(0, 4, rnd128());
    predict();
    base = mtx_count; n = 0;
    while (mtx_count < base + 2 && n < 300) begin tick(); n++; end
    chk(n < 300, "reset_mid_reach", n, 300);
    repeat (2) tick();
    rst_n = 1'b0;
    exp_grant.delete(); exp_mtx.delete(); exp_ack.delete(); exp_rx.delete(); exp_done.delete();
    for (int r = 0; r < NR; r++) pred_hd[r] = tl[r];
    model_ptr = NR - 1;
    tick();
    chk(cs_n == '1, "reset_mid_cs_n", cs_n, 3);
    chk(grant == '0, "reset_mid_grant", grant, 0);
    chk(done == '0, "reset_mid_done", done, 0);
    chk(busy == 1'b0, "reset_mid_busy", busy, 0);
    tick();
    rst_n = 1'b1;
    tick();
    issue(0, 2, rnd128());
    predict();
    wait_drain("drain_after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
